// File: rtl/apb_node_pkg.sv
// Shared types and constants for the APB watchdog node.
// Holds the FSM state encoding, error-counter width and default error read data.
package apb_node_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    ERR_RSP = 2'd2
  } node_state_e;

  localparam int unsigned ERR_CNT_W     = 16;
  localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/apb_bus.sv
// APB bus bundle carried between the bridge, the node and the downstream slaves.
// Master drives the request fields, slave returns prdata/pready/pslverr.
interface APB_BUS #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32
);
  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic [APB_DATA_WIDTH-1:0] pwdata;
  logic                      pwrite;
  logic                      psel;
  logic                      penable;
  logic [APB_DATA_WIDTH-1:0] prdata;
  logic                      pready;
  logic                      pslverr;

  modport Master (
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );

  modport Slave (
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_addr_dec.sv
// Combinational region decoder: one-hot match of the lowest-indexed region containing addr_i.
// Zero latency; no flow control.
module apb_addr_dec #(
  parameter int unsigned NB_MASTER      = 10,
  parameter int unsigned APB_ADDR_WIDTH = 32
) (
  input  logic [APB_ADDR_WIDTH-1:0]                addr_i,
  input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] start_addr_i,
  input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] end_addr_i,
  output logic [NB_MASTER-1:0]                     match_o,
  output logic                                     hit_o
);

  // Ascending scan: the first hit blocks all higher indices, so overlaps resolve to the lowest port.
  always_comb begin
    match_o = '0;
    hit_o   = 1'b0;
    for (int i = 0; i < NB_MASTER; i++) begin
      if (!hit_o && (addr_i >= start_addr_i[i]) && (addr_i <= end_addr_i[i])) begin
        match_o[i] = 1'b1;
        hit_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_node_wd.sv
// APB fan-out node with address decode, decode-error response and access-phase watchdog.
// Hit accesses add no latency; a stalled slave is cut off after TIMEOUT_CYCLES wait cycles.
module apb_node_wd
  import apb_node_pkg::*;
#(
  parameter int unsigned               NB_MASTER      = 10,
  parameter int unsigned               APB_ADDR_WIDTH = 32,
  parameter int unsigned               APB_DATA_WIDTH = 32,
  parameter int unsigned               TIMEOUT_CYCLES = 256,
  parameter logic [APB_DATA_WIDTH-1:0] ERR_RDATA      = APB_DATA_WIDTH'(ERR_RDATA_DEF)
) (
  input  logic                                     HCLK,
  input  logic                                     HRESETn,
  APB_BUS.Slave                                    apb_slave,
  APB_BUS.Master                                   apb_masters [NB_MASTER-1:0],
  input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] start_addr_i,
  input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] end_addr_i,
  output logic                                     timeout_o,
  output logic                                     decerr_o,
  output logic [ERR_CNT_W-1:0]                     err_cnt_o,
  output logic [APB_ADDR_WIDTH-1:0]                err_addr_o
);

  localparam int unsigned IDX_W     = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  node_state_e                             state_q;
  logic [IDX_W-1:0]                        sel_q;
  logic                                    hit_q;
  logic [15:0]                             wait_q;

  logic [NB_MASTER-1:0]                    dec_match;
  logic                                    dec_hit;
  logic [IDX_W-1:0]                        dec_idx;

  logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0] m_prdata;
  logic [NB_MASTER-1:0]                    m_pready;
  logic [NB_MASTER-1:0]                    m_pslverr;
  logic [NB_MASTER-1:0]                    m_psel;
  logic                                    slv_rdy;

  apb_addr_dec #(
    .NB_MASTER      (NB_MASTER),
    .APB_ADDR_WIDTH (APB_ADDR_WIDTH)
  ) u_dec (
    .addr_i       (apb_slave.paddr),
    .start_addr_i (start_addr_i),
    .end_addr_i   (end_addr_i),
    .match_o      (dec_match),
    .hit_o        (dec_hit)
  );

  always_comb begin
    dec_idx = '0;
    for (int i = 0; i < NB_MASTER; i++) begin
      if (dec_match[i]) dec_idx = IDX_W'(i);
    end
  end

  for (genvar i = 0; i < NB_MASTER; i++) begin : g_port
    assign apb_masters[i].paddr   = apb_slave.paddr;
    assign apb_masters[i].pwdata  = apb_slave.pwdata;
    assign apb_masters[i].pwrite  = apb_slave.pwrite;
    assign apb_masters[i].penable = apb_slave.penable;
    assign apb_masters[i].psel    = m_psel[i];
    assign m_prdata[i]            = apb_masters[i].prdata;
    assign m_pready[i]            = apb_masters[i].pready;
    assign m_pslverr[i]           = apb_masters[i].pslverr;
  end

  assign slv_rdy = m_pready[sel_q];

  // psel is gated by HRESETn so every downstream select drops the instant reset asserts.
  always_comb begin
    m_psel = '0;
    if (HRESETn && apb_slave.psel) begin
      case (state_q)
        IDLE:    m_psel = dec_match;
        ACCESS:  if (hit_q) m_psel[sel_q] = 1'b1;
        default: m_psel = '0;
      endcase
    end
  end

  always_comb begin
    apb_slave.pready  = 1'b0;
    apb_slave.pslverr = 1'b0;
    apb_slave.prdata  = '0;
    case (state_q)
      ACCESS: begin
        if (hit_q) begin
          apb_slave.pready  = slv_rdy;
          apb_slave.pslverr = m_pslverr[sel_q];
          apb_slave.prdata  = m_prdata[sel_q];
        end else begin
          apb_slave.pready  = 1'b1;
          apb_slave.pslverr = 1'b1;
          apb_slave.prdata  = ERR_RDATA;
        end
      end
      ERR_RSP: begin
        apb_slave.pready  = 1'b1;
        apb_slave.pslverr = 1'b1;
        apb_slave.prdata  = ERR_RDATA;
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      hit_q      <= 1'b0;
      wait_q     <= '0;
      timeout_o  <= 1'b0;
      decerr_o   <= 1'b0;
      err_cnt_o  <= '0;
      err_addr_o <= '0;
    end else begin
      timeout_o <= 1'b0;
      decerr_o  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (apb_slave.psel && !apb_slave.penable) begin
            state_q <= ACCESS;
            sel_q   <= dec_idx;
            hit_q   <= dec_hit;
            wait_q  <= '0;
          end
        end
        ACCESS: begin
          if (!apb_slave.psel) begin
            state_q <= IDLE;
          end else if (!hit_q) begin
            state_q    <= IDLE;
            decerr_o   <= 1'b1;
            err_cnt_o  <= sat_inc(err_cnt_o);
            err_addr_o <= apb_slave.paddr;
          end else if (slv_rdy) begin
            // A ready on the last allowed wait cycle still completes normally.
            state_q <= IDLE;
          end else begin
            wait_q <= wait_q + 16'd1;
            if (wait_q == WAIT_LAST) begin
              state_q    <= ERR_RSP;
              timeout_o  <= 1'b1;
              err_cnt_o  <= sat_inc(err_cnt_o);
              err_addr_o <= apb_slave.paddr;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
